// File: rtl/sram_like_rr_arbiter_if.sv
// Bundle of the NUM_CH upstream sram-like channels and the single downstream sram-like port.
// The arbiter uses the master view (it masters the downstream bus); the environment uses slave.
interface sram_like_rr_arbiter_if #(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [NUM_CH-1:0]        ch_req;
    logic [NUM_CH-1:0]        ch_wr;
    logic [2*NUM_CH-1:0]      ch_size;
    logic [ADDR_W*NUM_CH-1:0] ch_addr;
    logic [DATA_W*NUM_CH-1:0] ch_wdata;
    logic [NUM_CH-1:0]        ch_addr_ok;
    logic [NUM_CH-1:0]        ch_data_ok;
    logic [DATA_W-1:0]        ch_rdata;

    logic                     m_req;
    logic                     m_wr;
    logic [1:0]               m_size;
    logic [ADDR_W-1:0]        m_addr;
    logic [DATA_W-1:0]        m_wdata;
    logic                     m_addr_ok;
    logic                     m_data_ok;
    logic [DATA_W-1:0]        m_rdata;

    modport master (
        input  ch_req, ch_wr, ch_size, ch_addr, ch_wdata,
        output ch_addr_ok, ch_data_ok, ch_rdata,
        output m_req, m_wr, m_size, m_addr, m_wdata,
        input  m_addr_ok, m_data_ok, m_rdata
    );

    modport slave (
        output ch_req, ch_wr, ch_size, ch_addr, ch_wdata,
        input  ch_addr_ok, ch_data_ok, ch_rdata,
        input  m_req, m_wr, m_size, m_addr, m_wdata,
        output m_addr_ok, m_data_ok, m_rdata
    );
endinterface

// File: rtl/sram_like_rr_arbiter.sv
// Merges NUM_CH sram-like masters onto one downstream port, one transaction in flight,
// round-robin (RR_EN=1) or fixed lowest-index priority (RR_EN=0).
module sram_like_rr_arbiter #(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter bit RR_EN  = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    sram_like_rr_arbiter_if.master     bus,
    output logic [NUM_CH-1:0]          grant,
    output logic                       busy
);

    localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [NUM_CH-1:0] ONE_HOT = {{(NUM_CH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [NUM_CH-1:0]   grant_q, grant_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;

    logic [PTR_W-1:0]    win_idx;
    logic                win_found;
    logic [PTR_W-1:0]    gnt_idx;
    logic [PTR_W-1:0]    next_ptr;
    logic [PTR_W-1:0]    scan_sel;
    int                  scan_idx;
    logic                m_req;
    logic                mux_wr;
    logic [1:0]          mux_size;
    logic [ADDR_W-1:0]   mux_addr;
    logic [DATA_W-1:0]   mux_wdata;

    // Winner scan: starts at ptr with wrap-around, or at index 0 for fixed priority
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = 0;
        scan_sel  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (RR_EN) begin
                scan_idx = (int'(ptr_q) + k) % NUM_CH;
            end else begin
                scan_idx = k;
            end
            scan_sel = PTR_W'(scan_idx);
            if (!win_found && bus.ch_req[scan_sel]) begin
                win_found = 1'b1;
                win_idx   = scan_sel;
            end else begin
                win_found = win_found;
            end
        end
    end

    // Granted-channel index and AND-OR payload mux (all zero while grant is empty)
    always_comb begin
        gnt_idx   = '0;
        mux_wr    = 1'b0;
        mux_size  = 2'd0;
        mux_addr  = '0;
        mux_wdata = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            gnt_idx   = gnt_idx   | (PTR_W'(k) & {PTR_W{grant_q[k]}});
            mux_wr    = mux_wr    | (bus.ch_wr[k] & grant_q[k]);
            mux_size  = mux_size  | (bus.ch_size[2*k +: 2] & {2{grant_q[k]}});
            mux_addr  = mux_addr  | (bus.ch_addr[k*ADDR_W +: ADDR_W] & {ADDR_W{grant_q[k]}});
            mux_wdata = mux_wdata | (bus.ch_wdata[k*DATA_W +: DATA_W] & {DATA_W{grant_q[k]}});
        end
    end

    // Pointer moves just past the channel that completed
    always_comb begin
        if (gnt_idx == PTR_W'(NUM_CH - 1)) begin
            next_ptr = '0;
        end else begin
            next_ptr = gnt_idx + PTR_W'(1);
        end
    end

    // Downstream request follows the granted channel's req only while in ADDR
    always_comb begin
        m_req = (state_q == ST_ADDR) && ((bus.ch_req & grant_q) != '0);
    end

    // Next-state, grant and pointer update
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    grant_d = ONE_HOT << win_idx;
                    state_d = ST_ADDR;
                end else begin
                    grant_d = '0;
                end
            end
            ST_ADDR: begin
                if (!m_req) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                end else if (bus.m_addr_ok) begin
                    state_d = ST_DATA;
                end else begin
                    state_d = ST_ADDR;
                end
            end
            ST_DATA: begin
                if (bus.m_data_ok) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    if (RR_EN) begin
                        ptr_d = next_ptr;
                    end else begin
                        ptr_d = '0;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State, grant and pointer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    assign bus.m_req      = m_req;
    assign bus.m_wr       = mux_wr;
    assign bus.m_size     = mux_size;
    assign bus.m_addr     = mux_addr;
    assign bus.m_wdata    = mux_wdata;
    assign bus.ch_addr_ok = grant_q & {NUM_CH{m_req & bus.m_addr_ok}};
    assign bus.ch_data_ok = (state_q == ST_DATA) ? (grant_q & {NUM_CH{bus.m_data_ok}}) : '0;
    assign bus.ch_rdata   = bus.m_rdata;
    assign grant          = grant_q;
    assign busy           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sram_like_rr_arbiter.sv
// Directed bench: a per-cycle vector table for RR vs fixed-priority arbitration, then
// hand-written sequences for single read, delayed-accept write, abort, reset in DATA, wrap-around.
module tb_sram_like_rr_arbiter;

    logic clk;
    logic rst;
    logic [1:0] grant_a, grant_b;
    logic [2:0] grant_c;
    logic busy_a, busy_b, busy_c;
    int n_err;
    int n_chk;

    sram_like_rr_arbiter_if #(.NUM_CH(2), .ADDR_W(32), .DATA_W(32)) bus_a ();
    sram_like_rr_arbiter_if #(.NUM_CH(2), .ADDR_W(32), .DATA_W(32)) bus_b ();
    sram_like_rr_arbiter_if #(.NUM_CH(3), .ADDR_W(32), .DATA_W(32)) bus_c ();

    sram_like_rr_arbiter #(.NUM_CH(2), .ADDR_W(32), .DATA_W(32), .RR_EN(1'b1)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a), .grant(grant_a), .busy(busy_a));
    sram_like_rr_arbiter #(.NUM_CH(2), .ADDR_W(32), .DATA_W(32), .RR_EN(1'b0)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b), .grant(grant_b), .busy(busy_b));
    sram_like_rr_arbiter #(.NUM_CH(3), .ADDR_W(32), .DATA_W(32), .RR_EN(1'b1)) dut_c (
        .clk(clk), .rst(rst), .bus(bus_c), .grant(grant_c), .busy(busy_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  req;
        logic        aok_in;
        logic        dok_in;
        logic [1:0]  exp_ga;
        logic [1:0]  exp_gb;
        logic        exp_mreq;
        logic [1:0]  exp_aok;
        logic [1:0]  exp_dok;
        logic        exp_busy;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int mreq_cnt;
        int aok1_cnt;
        int aok0_cnt;
        n_err = 0;
        n_chk = 0;
        rst = 1'b1;
        bus_a.ch_req = 2'b11; bus_a.ch_wr = 2'b00; bus_a.ch_size = 4'b1010;
        bus_a.ch_addr = {32'h0000_2000, 32'h0000_1000}; bus_a.ch_wdata = 64'd0;
        bus_a.m_addr_ok = 1'b0; bus_a.m_data_ok = 1'b0; bus_a.m_rdata = 32'h1234_5678;
        bus_b.ch_req = 2'b11; bus_b.ch_wr = 2'b00; bus_b.ch_size = 4'b1010;
        bus_b.ch_addr = {32'h0000_2000, 32'h0000_1000}; bus_b.ch_wdata = 64'd0;
        bus_b.m_addr_ok = 1'b0; bus_b.m_data_ok = 1'b0; bus_b.m_rdata = 32'd0;
        bus_c.ch_req = 3'b000; bus_c.ch_wr = 3'b000; bus_c.ch_size = 6'b101010;
        bus_c.ch_addr = {32'h0000_3200, 32'h0000_3100, 32'h0000_3000}; bus_c.ch_wdata = 96'd0;
        bus_c.m_addr_ok = 1'b0; bus_c.m_data_ok = 1'b0; bus_c.m_rdata = 32'd0;

        //                req    aok   dok   ga     gb     mreq  aok    dok    busy  addr
        vecs[0]  = '{2'b11, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 32'h0};
        vecs[1]  = '{2'b11, 1'b1, 1'b1, 2'b01, 2'b01, 1'b1, 2'b01, 2'b00, 1'b1, 32'h1000};
        vecs[2]  = '{2'b11, 1'b1, 1'b1, 2'b01, 2'b01, 1'b0, 2'b00, 2'b01, 1'b1, 32'h1000};
        vecs[3]  = '{2'b11, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 32'h0};
        vecs[4]  = '{2'b11, 1'b1, 1'b1, 2'b10, 2'b01, 1'b1, 2'b10, 2'b00, 1'b1, 32'h2000};
        vecs[5]  = '{2'b11, 1'b1, 1'b1, 2'b10, 2'b01, 1'b0, 2'b00, 2'b10, 1'b1, 32'h2000};
        vecs[6]  = '{2'b11, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 32'h0};
        vecs[7]  = '{2'b11, 1'b1, 1'b1, 2'b01, 2'b01, 1'b1, 2'b01, 2'b00, 1'b1, 32'h1000};
        vecs[8]  = '{2'b11, 1'b1, 1'b1, 2'b01, 2'b01, 1'b0, 2'b00, 2'b01, 1'b1, 32'h1000};
        vecs[9]  = '{2'b11, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 32'h0};
        vecs[10] = '{2'b11, 1'b1, 1'b1, 2'b10, 2'b01, 1'b1, 2'b10, 2'b00, 1'b1, 32'h2000};
        vecs[11] = '{2'b11, 1'b1, 1'b1, 2'b10, 2'b01, 1'b0, 2'b00, 2'b10, 1'b1, 32'h2000};

        // Reset with requests pending: nothing may be granted
        repeat (2) @(posedge clk);
        #1;
        chk("reset grant_a", 32'(grant_a), 32'd0);
        chk("reset busy_a", 32'(busy_a), 32'd0);
        chk("reset m_req_a", 32'(bus_a.m_req), 32'd0);
        chk("reset addr_ok_a", 32'(bus_a.ch_addr_ok), 32'd0);
        chk("reset data_ok_a", 32'(bus_a.ch_data_ok), 32'd0);
        chk("reset m_addr_a", bus_a.m_addr, 32'd0);
        chk("reset grant_b", 32'(grant_b), 32'd0);
        rst = 1'b0;

        // Table: continuous requests from both channels, RR on A, fixed priority on B
        for (int i = 0; i < 12; i++) begin
            bus_a.ch_req = vecs[i].req;     bus_b.ch_req = vecs[i].req;
            bus_a.m_addr_ok = vecs[i].aok_in; bus_b.m_addr_ok = vecs[i].aok_in;
            bus_a.m_data_ok = vecs[i].dok_in; bus_b.m_data_ok = vecs[i].dok_in;
            #1;
            chk($sformatf("row%0d grant_a", i), 32'(grant_a), 32'(vecs[i].exp_ga));
            chk($sformatf("row%0d grant_b", i), 32'(grant_b), 32'(vecs[i].exp_gb));
            chk($sformatf("row%0d m_req_a", i), 32'(bus_a.m_req), 32'(vecs[i].exp_mreq));
            chk($sformatf("row%0d m_req_b", i), 32'(bus_b.m_req), 32'(vecs[i].exp_mreq));
            chk($sformatf("row%0d addr_ok_a", i), 32'(bus_a.ch_addr_ok), 32'(vecs[i].exp_aok));
            chk($sformatf("row%0d data_ok_a", i), 32'(bus_a.ch_data_ok), 32'(vecs[i].exp_dok));
            chk($sformatf("row%0d busy_a", i), 32'(busy_a), 32'(vecs[i].exp_busy));
            chk($sformatf("row%0d m_addr_a", i), bus_a.m_addr, vecs[i].exp_addr);
            step();
        end
        bus_a.ch_req = 2'b00; bus_a.m_addr_ok = 1'b0; bus_a.m_data_ok = 1'b0;
        bus_b.ch_req = 2'b00; bus_b.m_addr_ok = 1'b0; bus_b.m_data_ok = 1'b0;
        step();

        // Single read on channel 0
        bus_a.ch_req = 2'b01; bus_a.m_addr_ok = 1'b1;
        #1;
        chk("rd idle m_req", 32'(bus_a.m_req), 32'd0);
        chk("rd idle busy", 32'(busy_a), 32'd0);
        step();
        #1;
        chk("rd addr m_req", 32'(bus_a.m_req), 32'd1);
        chk("rd addr m_addr", bus_a.m_addr, 32'h0000_1000);
        chk("rd addr m_wr", 32'(bus_a.m_wr), 32'd0);
        chk("rd addr addr_ok", 32'(bus_a.ch_addr_ok), 32'd1);
        step();
        bus_a.ch_req = 2'b00; bus_a.m_addr_ok = 1'b0; bus_a.m_data_ok = 1'b1; bus_a.m_rdata = 32'hDEAD_BEEF;
        #1;
        chk("rd data m_req", 32'(bus_a.m_req), 32'd0);
        chk("rd data data_ok", 32'(bus_a.ch_data_ok), 32'd1);
        chk("rd data rdata", bus_a.ch_rdata, 32'hDEAD_BEEF);
        step();
        bus_a.m_data_ok = 1'b0;
        #1;
        chk("rd done grant", 32'(grant_a), 32'd0);
        chk("rd done busy", 32'(busy_a), 32'd0);
        chk("rd done data_ok", 32'(bus_a.ch_data_ok), 32'd0);

        // Channel 1 byte write with addr_ok delayed by 3 cycles of m_req
        bus_a.ch_wr = 2'b10; bus_a.ch_size = 4'b0010;
        bus_a.ch_addr = {32'h0000_2003, 32'h0000_1000}; bus_a.ch_wdata = {32'h0000_00AB, 32'h0};
        mreq_cnt = 0; aok1_cnt = 0; aok0_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            bus_a.ch_req = (k <= 3) ? 2'b10 : 2'b00;
            bus_a.m_addr_ok = (k == 3);
            bus_a.m_data_ok = (k == 4);
            #1;
            if (bus_a.m_req) begin
                mreq_cnt++;
                chk($sformatf("wr c%0d m_wr", k), 32'(bus_a.m_wr), 32'd1);
                chk($sformatf("wr c%0d m_size", k), 32'(bus_a.m_size), 32'd0);
                chk($sformatf("wr c%0d m_addr", k), bus_a.m_addr, 32'h0000_2003);
                chk($sformatf("wr c%0d m_wdata", k), bus_a.m_wdata, 32'h0000_00AB);
            end
            if (bus_a.ch_addr_ok[1]) aok1_cnt++;
            if (bus_a.ch_addr_ok[0]) aok0_cnt++;
            if (k == 4) chk("wr data_ok", 32'(bus_a.ch_data_ok), 32'd2);
            step();
        end
        chk("wr m_req cycles", 32'(mreq_cnt), 32'd3);
        chk("wr addr_ok1 pulses", 32'(aok1_cnt), 32'd1);
        chk("wr addr_ok0 pulses", 32'(aok0_cnt), 32'd0);
        chk("wr done grant", 32'(grant_a), 32'd0);
        bus_a.ch_wr = 2'b00; bus_a.ch_size = 4'b1010;

        // Request withdrawn before accept: back to IDLE, pointer unchanged (still 0)
        bus_a.ch_req = 2'b01;
        step();
        bus_a.ch_req = 2'b00;
        #1;
        chk("abort m_req", 32'(bus_a.m_req), 32'd0);
        chk("abort grant held", 32'(grant_a), 32'd1);
        step();
        #1;
        chk("abort grant", 32'(grant_a), 32'd0);
        chk("abort busy", 32'(busy_a), 32'd0);
        bus_a.ch_req = 2'b11; bus_a.m_addr_ok = 1'b1;
        step();
        #1;
        chk("abort ptr kept", 32'(grant_a), 32'd1);
        step();
        bus_a.ch_req = 2'b00; bus_a.m_addr_ok = 1'b0; bus_a.m_data_ok = 1'b1;
        #1;
        chk("abort retry data_ok", 32'(bus_a.ch_data_ok), 32'd1);
        step();
        bus_a.m_data_ok = 1'b0;

        // Reset while waiting for data_ok; the late data_ok must be ignored
        bus_a.ch_req = 2'b01; bus_a.m_addr_ok = 1'b1;
        step();
        step();
        bus_a.ch_req = 2'b00; bus_a.m_addr_ok = 1'b0;
        #1;
        chk("rstdata busy before", 32'(busy_a), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus_a.m_data_ok = 1'b1;
        #1;
        chk("rstdata busy", 32'(busy_a), 32'd0);
        chk("rstdata grant", 32'(grant_a), 32'd0);
        chk("rstdata data_ok", 32'(bus_a.ch_data_ok), 32'd0);
        step();
        bus_a.m_data_ok = 1'b0;
        #1;
        chk("rstdata busy after", 32'(busy_a), 32'd0);

        // Three channels: complete on ch1 (ptr->2), then ch0 wins over ch1 by wrap
        bus_c.ch_req = 3'b010; bus_c.m_addr_ok = 1'b1;
        step();
        #1;
        chk("c first grant", 32'(grant_c), 32'd2);
        step();
        bus_c.ch_req = 3'b000; bus_c.m_addr_ok = 1'b0; bus_c.m_data_ok = 1'b1;
        #1;
        chk("c first data_ok", 32'(bus_c.ch_data_ok), 32'd2);
        step();
        bus_c.m_data_ok = 1'b0; bus_c.ch_req = 3'b011; bus_c.m_addr_ok = 1'b1;
        #1;
        chk("c ptr two", 32'(dut_c.ptr_q), 32'd2);
        step();
        #1;
        chk("c wrap grant", 32'(grant_c), 32'd1);
        chk("c wrap m_addr", bus_c.m_addr, 32'h0000_3000);
        step();
        bus_c.ch_req = 3'b000; bus_c.m_addr_ok = 1'b0; bus_c.m_data_ok = 1'b1;
        #1;
        chk("c wrap data_ok", 32'(bus_c.ch_data_ok), 32'd1);
        step();
        bus_c.m_data_ok = 1'b0;
        #1;
        chk("c ptr one", 32'(dut_c.ptr_q), 32'd1);
        chk("c idle busy", 32'(busy_c), 32'd0);
        bus_c.ch_req = 3'b011;
        step();
        #1;
        chk("c next grant", 32'(grant_c), 32'd2);
        bus_c.ch_req = 3'b000;
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/sram_like_rr_arbiter.md
Name: sram_like_rr_arbiter

Overview:
- Parametrised N-channel arbiter that merges NUM_CH sram-like master interfaces onto one downstream sram-like slave port.
- Typical channels: instruction fetch, data access, uncached/DMA.
- Supports one outstanding transaction at a time. Grant is held from arbitration until the slave returns data_ok.
- Arbitration is round-robin, or fixed-priority (channel 0 highest) when RR_EN=0.

Parameters:
- NUM_CH, 2, number of requesting channels (2..8)
- ADDR_W, 32, address width
- DATA_W, 32, data width
- RR_EN, 1, 1 = round-robin, 0 = fixed priority, lowest index wins

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ch_req  in  NUM_CH  per-channel request
- ch_wr  in  NUM_CH  per-channel write flag
- ch_size  in  2*NUM_CH  per-channel size: 0=byte, 1=half, 2=word
- ch_addr  in  ADDR_W*NUM_CH  per-channel address, flattened, channel i at [i*ADDR_W +: ADDR_W]
- ch_wdata  in  DATA_W*NUM_CH  per-channel write data, flattened
- ch_addr_ok  out  NUM_CH  address accepted, granted channel only
- ch_data_ok  out  NUM_CH  transaction complete, granted channel only
- ch_rdata  out  DATA_W  read data, broadcast to all channels, valid only with ch_data_ok
- m_req  out  1  downstream request
- m_wr  out  1  downstream write flag
- m_size  out  2  downstream size
- m_addr  out  ADDR_W  downstream address
- m_wdata  out  DATA_W  downstream write data
- m_addr_ok  in  1  downstream address accepted
- m_data_ok  in  1  downstream data complete
- m_rdata  in  DATA_W  downstream read data
- grant  out  NUM_CH  one-hot current grant, 0 when idle
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values (rst=1 at a clk edge):
  - state=IDLE, grant=0, priority pointer ptr=0.
  - m_req=0, busy=0.
  - ch_addr_ok=0, ch_data_ok=0.
  - m_wr, m_size, m_addr, m_wdata are 0 while grant=0.
  - Reset mid-transaction abandons it; any later m_data_ok while IDLE is ignored.
- States:
  - IDLE: if any ch_req, register the winner into grant, go to ADDR. Arbitration costs 1 cycle; m_req stays 0 in IDLE.
  - ADDR: m_req = ch_req[granted]. m_wr, m_size, m_addr, m_wdata are combinational muxes of the granted channel's inputs.
    - ch_addr_ok[g] = m_addr_ok & m_req (combinational).
    - On m_addr_ok & m_req, go to DATA.
    - If ch_req[g] drops before accept, go to IDLE; grant cleared, ptr unchanged.
  - DATA: m_req=0. Payload muxes stay on the granted channel.
    - ch_data_ok[g] = m_data_ok, and ch_rdata = m_rdata (both combinational).
    - On m_data_ok: go to IDLE, grant cleared.
    - If RR_EN=1, ptr <= (g+1) mod NUM_CH.
- Winner selection:
  - RR_EN=1: first requesting index scanning ptr, ptr+1, ... with wrap-around modulo NUM_CH.
  - RR_EN=0: lowest requesting index; ptr is unused and stays 0.
- Timing and isolation:
  - Minimum transaction is 3 cycles (IDLE, ADDR, DATA) for a slave with zero-wait addr_ok and next-cycle data_ok.
  - The slave guarantees data_ok arrives at least 1 cycle after addr_ok. m_data_ok in IDLE or ADDR is ignored.
  - Non-granted channels always see addr_ok=0 and data_ok=0. A new request arriving mid-transaction waits for IDLE.
  - A channel must hold req, addr, wr, size and wdata stable until its addr_ok.
- Width: ptr is clog2(NUM_CH) bits, minimum 1. No arithmetic on payload.

Test Plan:
- Single read: reset, ch_req=2'b01, ch_addr[0]=0x1000, slave addr_ok on first m_req cycle, data_ok next cycle with rdata=0xDEADBEEF.
  -> m_req high 1 cycle with m_addr=0x1000; ch_data_ok=2'b01, ch_rdata=0xDEADBEEF; grant back to 0.
- Round-robin fairness: both channels request continuously, RR_EN=1.
  -> grants alternate 01, 10, 01, 10 across 4 transactions.
- Fixed priority: same stimulus with RR_EN=0.
  -> all 4 grants go to 01 while ch_req[0] is held.
- Write pass-through: ch1 write, size=0, addr=0x2003, wdata=0x000000AB, slave addr_ok delayed 3 cycles.
  -> m_req held 3 cycles with m_wr=1, m_size=0, m_addr=0x2003; ch_addr_ok[1] pulses once; ch_addr_ok[0] stays 0.
- Wrap-around: NUM_CH=3, ptr=2, requests from ch0 and ch1.
  -> ch0 wins; after completion ptr=1.
- Reset in DATA: assert rst while waiting on data_ok, then m_data_ok=1.
  -> state IDLE, busy=0, no ch_data_ok pulse.
